// File: rtl/gate2ip_bist.sv
// ============================================================================
// Module   : gate2ip_bist
// Purpose  : Self-checking driver/monitor for a 2-input gate. Sweeps {a,b} in
//            Gray order, compares y against TRUTH and reports verdicts.
// Option   : GATE2IP_BIST_STOP_ON_FAIL_EN ends the test on the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate2ip_bist #(
   parameter logic [3:0]  TRUTH  = 4'b0001,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned PASSES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);
   localparam logic [3:0] c_pass_last   = 4'(PASSES - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_settle;
   logic [1:0] r_vec;
   logic [3:0] r_pass;

   logic [1:0] w_ab;
   logic [1:0] w_vec_nxt;
   logic       w_mismatch;
   logic       w_last;
   logic       w_stop;

   assign w_ab       = {gate_a, gate_b};
   assign w_vec_nxt  = r_vec + 2'd1;
   assign w_mismatch = (gate_y != TRUTH[w_ab]);
   assign w_last     = (r_vec == 2'd3) && (r_pass == c_pass_last);

`ifdef GATE2IP_BIST_STOP_ON_FAIL_EN
   assign w_stop = w_last | w_mismatch;
`else
   assign w_stop = w_last;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_DRIVE;
         S_DRIVE:  if (r_settle == c_settle_last) w_next = S_SAMPLE;
         S_SAMPLE: w_next = w_stop ? S_FINISH : S_DRIVE;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gate_a   <= 1'b0;
         gate_b   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= 4'd0;
         fail_vec <= 4'd0;
         r_settle <= 4'd0;
         r_vec    <= 2'd0;
         r_pass   <= 4'd0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               gate_a   <= 1'b0;
               gate_b   <= 1'b0;
               r_settle <= 4'd0;
               if (start) begin
                  err_cnt  <= 4'd0;
                  fail_vec <= 4'd0;
                  pass     <= 1'b0;
                  r_vec    <= 2'd0;
                  r_pass   <= 4'd0;
                  busy     <= 1'b1;
               end
            end
            S_DRIVE: begin
               r_settle <= (r_settle == c_settle_last) ? 4'd0 : r_settle + 4'd1;
            end
            S_SAMPLE: begin
               if (w_mismatch) begin
                  if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
                  fail_vec[w_ab] <= 1'b1;
               end
               if (!w_stop) begin
                  r_vec <= w_vec_nxt;
                  if (r_vec == 2'd3) r_pass <= r_pass + 4'd1;
                  // Index to Gray code: 0,1,2,3 -> 00,01,11,10
                  gate_a <= w_vec_nxt[1];
                  gate_b <= w_vec_nxt[1] ^ w_vec_nxt[0];
               end
            end
            S_FINISH: begin
               done   <= 1'b1;
               busy   <= 1'b0;
               pass   <= (err_cnt == 4'd0);
               gate_a <= 1'b0;
               gate_b <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gate2ip_bist.sv
// ============================================================================
// Module   : tb_gate2ip_bist
// Purpose  : Randomized self-checking bench for gate2ip_bist; two instances
//            (default and SETTLE=3/PASSES=6) against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate2ip_bist;

   localparam logic [3:0] NOR_TT = 4'b0001;
   localparam int S0 = 2, P0 = 1;
   localparam int S1 = 3, P1 = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [3:0] resp0 = NOR_TT, resp1 = NOR_TT;
   logic gate_y0, gate_a0, gate_b0, busy0, done0, pass0;
   logic gate_y1, gate_a1, gate_b1, busy1, done1, pass1;
   logic [3:0] err0, fv0, err1, fv1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Simulated gate under test: response table indexed by {a,b}
   assign gate_y0 = resp0[{gate_a0, gate_b0}];
   assign gate_y1 = resp1[{gate_a1, gate_b1}];

   gate2ip_bist #(.TRUTH(NOR_TT), .SETTLE(S0), .PASSES(P0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .gate_y(gate_y0),
      .gate_a(gate_a0), .gate_b(gate_b0), .busy(busy0), .done(done0),
      .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
   );

   gate2ip_bist #(.TRUTH(NOR_TT), .SETTLE(S1), .PASSES(P1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .gate_y(gate_y1),
      .gate_a(gate_a1), .gate_b(gate_b1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Gray sweep order as {a,b} codes
   function automatic logic [1:0] seq_ab(input int k);
      logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      return order[k % 4];
   endfunction

   task automatic model(input logic [3:0] resp, input int s, input int p,
                        output int err, output logic [3:0] fv,
                        output logic ps, output int lat);
      logic [3:0] miss;
      int bad, first;
      miss  = resp ^ NOR_TT;
      bad   = $countones(miss) * p;
      err   = (bad > 15) ? 15 : bad;
      fv    = miss;
      ps    = (miss == 4'd0);
      lat   = 4 * (s + 1) * p + 1;
`ifdef GATE2IP_BIST_STOP_ON_FAIL_EN
      first = -1;
      for (int k = 3; k >= 0; k--)
         if (miss[seq_ab(k)]) first = k;
      if (first >= 0) begin
         err = 1;
         fv  = 4'd0;
         fv[seq_ab(first)] = 1'b1;
         lat = (first + 1) * (s + 1) + 1;
      end
`else
      first = 0;
      if (first != 0) lat = 0;
`endif
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_d0"}, {gate_a0, gate_b0, busy0, done0, pass0, err0, fv0}, 0);
      check({tag, "_d1"}, {gate_a1, gate_b1, busy1, done1, pass1, err1, fv1}, 0);
   endtask

   task automatic run_pair(input logic [3:0] r0, input logic [3:0] r1);
      int e0, e1, l0, l1;
      logic [3:0] f0, f1;
      logic p0, p1, got0, got1;
      model(r0, S0, P0, e0, f0, p0, l0);
      model(r1, S1, P1, e1, f1, p1, l1);
      resp0 = r0; resp1 = r1;
      start0 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      check("ab_t0", {gate_a0, gate_b0}, 2'b00);
      check("busy_t0", busy0, 1'b1);
      got0 = 1'b0; got1 = 1'b0;
      for (int t = 1; t <= 200 && !(got0 && got1); t++) begin
         @(posedge clk); #1;
         if (!got0) begin
            if (t <= l0 - 2) check("ab_trace", {gate_a0, gate_b0}, seq_ab(t / (S0 + 1)));
            if (done0) begin
               got0 = 1'b1;
               check("lat0", t, l0);
               check("err0", err0, e0);
               check("fv0", fv0, f0);
               check("pass0", pass0, p0);
               check("busy0_end", busy0, 1'b0);
            end
         end
         if (!got1 && done1) begin
            got1 = 1'b1;
            check("lat1", t, l1);
            check("err1", err1, e1);
            check("fv1", fv1, f1);
            check("pass1", pass1, p1);
         end
      end
      if (!got0) check("timeout0", 0, 1);
      if (!got1) check("timeout1", 0, 1);
      @(posedge clk); #1;
      check("done0_pulse", done0, 1'b0);
      check("hold0", {pass0, err0, fv0}, {p0, 4'(e0), f0});
   endtask

   initial begin
      int gap, ndone;
      logic seen;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_pair(NOR_TT, 4'b0000);   // correct gate / stuck-at-0
      run_pair(4'b0000, 4'b1111);  // stuck-at-0 / stuck-at-1 (saturation)
      run_pair(4'b1111, NOR_TT);
      for (int i = 0; i < 10; i++)
         run_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      // Restart ignored while busy, then reset mid-test
      resp0 = NOR_TT; resp1 = NOR_TT;
      start0 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         @(posedge clk); #1;
         if (t == 5) begin start0 = 1'b1; start1 = 1'b1; end
         if (t == 6) begin
            start0 = 1'b0; start1 = 1'b0;
            check("restart_ab", {gate_a0, gate_b0}, 2'b11);
            check("restart_busy", busy0, 1'b1);
         end
         if (t == 7) rst_n = 1'b0;
      end
      @(posedge clk); #1;
      check_idle_zero("midreset");
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done0 || done1) ndone++;
      end
      check("no_done_after_rst", ndone, 0);
      run_pair(NOR_TT, NOR_TT);

      // Back-to-back with start held high
      resp0 = NOR_TT;
      start0 = 1'b1;
      seen = 1'b0; gap = 0;
      for (int t = 1; t <= 100; t++) begin
         @(posedge clk); #1;
         if (seen) gap++;
         if (done0) begin
            if (seen) begin
               start0 = 1'b0;
               break;
            end
            seen = 1'b1;
         end
      end
      start0 = 1'b0;
      check("b2b_gap", gap, 4 * (S0 + 1) * P0 + 2);
      repeat (3) @(posedge clk);
      #1;
      check("b2b_idle", busy0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
